// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        longint prod;
        prod = longint'(baud_rate) * longint'(oversample);
        return int'(longint'(clk_freq) / prod);
    endfunction

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, held in phase by clear.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk_fpga,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority voting, false-start rejection,
// error flags and a valid/ack holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 9_600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk_fpga,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int            DIV       = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int            SW        = cnt_w(OVERSAMPLE);
    localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam int            BW        = cnt_w(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam parity_e       PAR_CFG   = (PARITY_MODE == 1) ? PAR_ODD :
                                          (PARITY_MODE == 2) ? PAR_EVEN : PAR_NONE;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        case (PAR_CFG)
            PAR_ODD:  return ~(^d ^ p);
            PAR_EVEN: return ^d ^ p;
            default:  return 1'b0;
        endcase
    endfunction

    rx_state_e            state, state_nxt;
    logic                 rx_sync_p0, rx_sync_p1, rx_prev_p2;
    logic                 vld_p0, vld_p1, armed;
    logic                 tick;
    logic [SW-1:0]        s_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 vote_lo, vote_mid;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, stop_low, stop_high;
    logic                 commit_req;
    logic                 sample_lo, sample_mid, vote_now, bit_end, vote_bit;
    logic                 start_edge, last_stop_vote;

    // Stage p0/p1: synchroniser; p2: previous synced value for edge detection.
    // vld_pN marks when the sync chain holds real line samples rather than reset values.
    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev_p2 <= 1'b1;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            armed      <= 1'b0;
        end else begin
            rx_sync_p0 <= rx_in;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev_p2 <= rx_sync_p1;
            vld_p0     <= 1'b1;
            vld_p1     <= vld_p0;
            if (vld_p1 && rx_sync_p1) armed <= 1'b1;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .clear    (state == IDLE),
        .tick     (tick)
    );

    assign sample_lo      = tick && (s_cnt == S_LO);
    assign sample_mid     = tick && (s_cnt == S_MID);
    assign vote_now       = tick && (s_cnt == S_HI);
    assign bit_end        = tick && (s_cnt == S_LAST);
    assign vote_bit       = majority(vote_lo, vote_mid, rx_sync_p1);
    assign start_edge     = armed && rx_prev_p2 && !rx_sync_p1;
    assign last_stop_vote = (state == STOP) && vote_now && (stop_cnt == STOP_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_edge) state_nxt = START;
            START: begin
                if (vote_now && vote_bit) state_nxt = IDLE;
                else if (bit_end)         state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == BIT_LAST)
                    state_nxt = (PAR_CFG != PAR_NONE) ? PARITY : STOP;
            end
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (last_stop_vote) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Stage p3: bit timing, vote samples and frame assembly.
    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            s_cnt      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            vote_lo    <= 1'b1;
            vote_mid   <= 1'b1;
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop_low   <= 1'b0;
            stop_high  <= 1'b0;
            commit_req <= 1'b0;
        end else begin
            commit_req <= last_stop_vote;
            if (state == IDLE)  s_cnt <= '0;
            else if (tick)      s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
            if (sample_lo)  vote_lo  <= rx_sync_p1;
            if (sample_mid) vote_mid <= rx_sync_p1;
            case (state)
                IDLE: begin
                    bit_cnt   <= '0;
                    stop_cnt  <= 1'b0;
                    stop_low  <= 1'b0;
                    stop_high <= 1'b0;
                end
                DATA: begin
                    if (vote_now) shreg <= {vote_bit, shreg[DATA_BITS-1:1]};
                    if (bit_end)  bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
                end
                PARITY: if (vote_now) par_bit <= vote_bit;
                STOP: begin
                    if (vote_now) begin
                        if (vote_bit) stop_high <= 1'b1;
                        else          stop_low  <= 1'b1;
                    end
                    if (bit_end) stop_cnt <= stop_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Stage p4: holding register; a new frame lands only if the old one is gone or acked now.
    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (commit_req && (!rx_valid || rx_ack)) begin
            rx_data    <= shreg;
            rx_valid   <= 1'b1;
            parity_err <= parity_bad(shreg, par_bit);
            frame_err  <= stop_low;
            break_det  <= (shreg == '0) && !par_bit && !stop_high;
            if (rx_ack) overrun_err <= 1'b0;
        end else if (commit_req) begin
            overrun_err <= 1'b1;
        end else if (rx_ack && rx_valid) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 7E1 and 8N2 instances at 32 clocks per bit.
module tb_uart_rx_param;

    localparam int CLK_FREQ = 16_000_000;
    localparam int BAUD     = 500_000;
    localparam int OS       = 16;
    localparam int BIT_CLK  = 32;

    logic       clk_fpga = 1'b0;
    logic       reset;
    logic [2:0] rx_line;
    logic [2:0] ack_line;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic [2:0] valid, perr, ferr, brk, ovr, busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_fpga = ~clk_fpga;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .clk_fpga(clk_fpga), .reset(reset), .rx_in(rx_line[0]), .rx_ack(ack_line[0]),
        .rx_data(data_a), .rx_valid(valid[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
        .break_det(brk[0]), .overrun_err(ovr[0]), .rx_busy(busy[0]));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
        .clk_fpga(clk_fpga), .reset(reset), .rx_in(rx_line[1]), .rx_ack(ack_line[1]),
        .rx_data(data_b), .rx_valid(valid[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
        .break_det(brk[1]), .overrun_err(ovr[1]), .rx_busy(busy[1]));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
        .clk_fpga(clk_fpga), .reset(reset), .rx_in(rx_line[2]), .rx_ack(ack_line[2]),
        .rx_data(data_c), .rx_valid(valid[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
        .break_det(brk[2]), .overrun_err(ovr[2]), .rx_busy(busy[2]));

    // flags packed as {valid, parity_err, frame_err, break_det, overrun_err}
    typedef struct {
        int          sel;
        logic [15:0] bits;
        int          nbits;
        logic [15:0] spike;
        logic [8:0]  exp_data;
        logic [4:0]  exp_fl;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic clks(input int n);
        repeat (n) @(negedge clk_fpga);
    endtask

    task automatic check(input string name, input int sel, input logic [8:0] exp_data,
                         input logic [4:0] exp_fl);
        logic [8:0] d;
        logic [4:0] f;
        case (sel)
            0:       d = {1'b0, data_a};
            1:       d = {2'b0, data_b};
            default: d = {1'b0, data_c};
        endcase
        f = {valid[sel], perr[sel], ferr[sel], brk[sel], ovr[sel]};
        n_vec++;
        if (d !== exp_data || f !== exp_fl) begin
            n_bad++;
            $display("FAIL %s: got data=%h flags(v,p,f,b,o)=%b, expected data=%h flags=%b",
                     name, d, f, exp_data, exp_fl);
        end
    endtask

    task automatic check_busy(input string name, input int sel, input logic exp);
        n_vec++;
        if (busy[sel] !== exp) begin
            n_bad++;
            $display("FAIL %s: rx_busy got %b, expected %b", name, busy[sel], exp);
        end
    endtask

    // Bits go LSB first; a spike inverts bit i for two clocks around its centre sample.
    task automatic send_frame(input int sel, input logic [15:0] bits, input int nbits,
                              input logic [15:0] spike);
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < BIT_CLK; j++) begin
                rx_line[sel] = bits[i] ^ (spike[i] && (j == 18 || j == 19));
                @(negedge clk_fpga);
            end
        end
        rx_line[sel] = 1'b1;
    endtask

    task automatic ack(input int sel);
        ack_line[sel] = 1'b1;
        @(negedge clk_fpga);
        ack_line[sel] = 1'b0;
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16'h0000, 9'h0A5, 5'b10000, "8n1_a5"};
        vecs[1] = '{0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 16'h0102, 9'h00F, 5'b10000, "8n1_spike"};
        vecs[2] = '{0, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 16'h0000, 9'h000, 5'b10000, "8n1_zero"};
        vecs[3] = '{0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 16'h0000, 9'h0FF, 5'b10000, "8n1_ff"};
        vecs[4] = '{1, {6'b0, 1'b1, 1'b0, 7'h55, 1'b0}, 10, 16'h0000, 9'h055, 5'b10000, "7e1_good"};
        vecs[5] = '{1, {6'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 10, 16'h0000, 9'h055, 5'b11000, "7e1_bad"};
        vecs[6] = '{2, {5'b0, 2'b11, 8'h81, 1'b0}, 11, 16'h0000, 9'h081, 5'b10000, "8n2_good"};
        vecs[7] = '{2, {5'b0, 2'b01, 8'hC3, 1'b0}, 11, 16'h0000, 9'h0C3, 5'b10100, "8n2_stop2low"};
        vecs[8] = '{2, 16'h0000, 11, 16'h0000, 9'h000, 5'b10110, "8n2_break"};

        reset    = 1'b0;
        rx_line  = 3'b111;
        ack_line = 3'b000;
        clks(4);
        reset = 1'b1;
        clks(4);
        for (int s = 0; s < 3; s++) begin
            check("reset_state", s, 9'h000, 5'b00000);
            check_busy("reset_busy", s, 1'b0);
        end

        foreach (vecs[v]) begin
            send_frame(vecs[v].sel, vecs[v].bits, vecs[v].nbits, vecs[v].spike);
            clks(2);
            check(vecs[v].name, vecs[v].sel, vecs[v].exp_data, vecs[v].exp_fl);
            ack(vecs[v].sel);
            check({vecs[v].name, "_ack"}, vecs[v].sel, vecs[v].exp_data, 5'b00000);
            clks(8);
        end

        // Short low glitch on an idle line must be rejected as a false start.
        rx_line[0] = 1'b0;
        clks(6);
        rx_line[0] = 1'b1;
        clks(2);
        check_busy("glitch_started", 0, 1'b1);
        clks(30);
        check_busy("glitch_rejected", 0, 1'b0);
        check("glitch_no_frame", 0, 9'h0FF, 5'b00000);

        // Two frames without ack: first is held, second sets overrun.
        send_frame(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, 16'h0);
        send_frame(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, 16'h0);
        clks(2);
        check("overrun_held", 0, 9'h011, 5'b10001);
        ack(0);
        check("overrun_ack", 0, 9'h011, 5'b00000);
        clks(8);

        // Ack exactly on the commit clock of the second frame: it replaces the held one.
        send_frame(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, 16'h0);
        fork
            send_frame(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, 16'h0);
            begin : watcher
                int k;
                k = 0;
                while (!busy[0] && k < 200) begin @(negedge clk_fpga); k++; end
                k = 0;
                while (busy[0] && k < 600) begin @(negedge clk_fpga); k++; end
                if (busy[0]) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL ack_watch: rx_busy stuck at 1, expected 0");
                end else begin
                    ack(0);
                end
            end
        join
        clks(2);
        check("ack_on_commit", 0, 9'h022, 5'b10000);

        // Reset mid-DATA with the line low through release.
        rx_line[0] = 1'b0;
        clks(BIT_CLK);
        rx_line[0] = 1'b1;
        clks(BIT_CLK);
        rx_line[0] = 1'b0;
        clks(16);
        check_busy("mid_data_busy", 0, 1'b1);
        reset = 1'b0;
        clks(3);
        check("in_reset", 0, 9'h000, 5'b00000);
        check_busy("in_reset_busy", 0, 1'b0);
        reset = 1'b1;
        clks(12 * BIT_CLK);
        check("low_after_reset", 0, 9'h000, 5'b00000);
        check_busy("low_after_reset_busy", 0, 1'b0);
        rx_line[0] = 1'b1;
        clks(2 * BIT_CLK);
        send_frame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 16'h0);
        clks(2);
        check("after_reset_3c", 0, 9'h03C, 5'b10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
